// File: rtl/adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// adc_capture_buffer
//
// Multi-channel triggered capture buffer on the ADC clock domain. It records
// N_CH signed sample streams into a circular RAM and keeps a programmable
// number of pre-trigger samples. After the trigger it finishes the record.
// The frozen record of DEPTH = 2**ADDR_W time steps is then streamed out
// oldest-first over a valid/ready interface.
//
// Optional feature macro: CAPTURE_DECIM_EN
//   When defined, a 16-bit decimation counter selects which samples are
//   stored (every decim_i+1 cycles). The trigger sample is always stored.
//   When undefined, every sample is stored and decim_i is ignored.
//
// Ports
//   adc_clk_i    ADC sample clock, all logic on the rising edge
//   adc_rst_i    synchronous active-high reset
//   adc_dat_i    N_CH samples per cycle, channel 0 in the LSBs
//   arm_i        pulse: start a new capture (honoured in IDLE and READ)
//   abort_i      pulse: cancel capture/readout, back to IDLE (beats arm_i)
//   ext_trig_i   external trigger, rising edge detected internally
//   trig_src_i   0..N_CH-1 level trigger on that channel, 3 = external
//   trig_lvl_i   signed trigger level
//   pre_len_i    pre-trigger sample count, sampled on arm
//   decim_i      decimation factor minus one, sampled on arm
//   m_data_o     readout word, all channels of one time step
//   m_valid_o    readout word valid
//   m_ready_i    readout consumer ready
//   m_last_o     marks the final word of the record
//   state_o      FSM state (0 IDLE, 1 PREFILL, 2 WAIT_TRIG, 3 POST, 4 READ)
//   trig_addr_o  RAM address holding the trigger sample
// ---------------------------------------------------------------------------
module adc_capture_buffer #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
) (
    input  logic                     adc_clk_i,
    input  logic                     adc_rst_i,
    input  logic [N_CH*DATA_W-1:0]   adc_dat_i,
    input  logic                     arm_i,
    input  logic                     abort_i,
    input  logic                     ext_trig_i,
    input  logic [1:0]               trig_src_i,
    input  logic [DATA_W-1:0]        trig_lvl_i,
    input  logic [ADDR_W-1:0]        pre_len_i,
    input  logic [15:0]              decim_i,
    output logic [N_CH*DATA_W-1:0]   m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o,
    output logic [2:0]               state_o,
    output logic [ADDR_W-1:0]        trig_addr_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int SW    = N_CH*DATA_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_READ      = 3'd4
    } state_t;

    state_t             r_state;
    logic [SW-1:0]      r_mem [DEPTH];
    logic [SW-1:0]      r_prev;
    logic               r_ext_prev;
    logic [ADDR_W-1:0]  r_pre;
    logic [ADDR_W-1:0]  r_wptr;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  r_trig_addr;
    logic [ADDR_W-1:0]  r_raddr;
    logic [ADDR_W-1:0]  r_issued;
    logic               r_rd_done;
    logic               r_rd_pend;
    logic               r_rd_last;
    logic [SW-1:0]      r_rdata;
    logic [SW-1:0]      r_out_data;
    logic               r_valid;
    logic               r_last;
    logic [SW-1:0]      r_skid_data;
    logic               r_skid_valid;
    logic               r_skid_last;

    logic               w_lvl_hit;
    logic               w_ext_hit;
    logic               w_trig;
    logic               w_store;
    logic               w_capture;
    logic               w_we;
    logic               w_xfer;
    logic               w_issue;
    logic [1:0]         w_occ;
    logic [ADDR_W-1:0]  w_post_len;

    // Level trigger on the selected channel: previous full-rate sample below
    // the level and current one at or above it, compared as signed values.
    // Source code 3 always means the external trigger, even when N_CH is 4.
    always_comb begin
        w_lvl_hit = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(trig_src_i) == c && trig_src_i != 2'd3) begin
                w_lvl_hit = ($signed(r_prev[c*DATA_W +: DATA_W]) < $signed(trig_lvl_i)) &&
                            ($signed(adc_dat_i[c*DATA_W +: DATA_W]) >= $signed(trig_lvl_i));
            end
        end
    end

    assign w_ext_hit  = (trig_src_i == 2'd3) && ext_trig_i && !r_ext_prev;
    assign w_trig     = (r_state == S_WAIT_TRIG) && (w_lvl_hit || w_ext_hit);
    assign w_capture  = (r_state == S_PREFILL) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
    // DEPTH-1-pre equals the bitwise inverse of pre in ADDR_W bits.
    assign w_post_len = ~r_pre;

`ifdef CAPTURE_DECIM_EN
    logic [15:0] r_decim;
    logic [15:0] r_dcnt;
    assign w_store = (r_dcnt == r_decim) || w_trig;
`else
    logic w_unused_decim;
    assign w_unused_decim = ^decim_i;
    assign w_store        = 1'b1;
`endif

    assign w_we   = w_capture && w_store;
    assign w_xfer = r_valid && m_ready_i;
    // Words in the output register, the skid register and the RAM pipeline.
    // A read is issued only if its data will have a slot one cycle later.
    assign w_occ   = 2'(r_valid) + 2'(r_skid_valid) + 2'(r_rd_pend);
    assign w_issue = (r_state == S_READ) && !r_rd_done && !arm_i && !abort_i &&
                     ((w_occ - 2'(w_xfer)) < 2'd2);

    // Sample RAM: one write port during capture and a registered read port
    // during readout. The contents need no reset.
    always_ff @(posedge adc_clk_i) begin
        if (w_we) begin
            r_mem[r_wptr] <= adc_dat_i;
        end
        if (w_issue) begin
            r_rdata <= r_mem[r_raddr];
        end
    end

    // Capture/readout FSM with trigger history, pointers and the output skid
    // stage. Abort beats arm. Arm restarts a capture from IDLE or READ.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_ext_prev   <= 1'b0;
            r_pre        <= '0;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_trig_addr  <= '0;
            r_raddr      <= '0;
            r_issued     <= '0;
            r_rd_done    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_last    <= 1'b0;
            r_out_data   <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
`ifdef CAPTURE_DECIM_EN
            r_decim      <= '0;
            r_dcnt       <= '0;
`endif
        end else begin
            r_prev     <= adc_dat_i;
            r_ext_prev <= ext_trig_i;
            r_rd_pend  <= w_issue;
`ifdef CAPTURE_DECIM_EN
            if (w_capture) begin
                r_dcnt <= w_store ? 16'd0 : r_dcnt + 16'd1;
            end
`endif
            if (abort_i) begin
                r_state      <= S_IDLE;
                r_valid      <= 1'b0;
                r_last       <= 1'b0;
                r_skid_valid <= 1'b0;
                r_rd_pend    <= 1'b0;
            end else if (arm_i && (r_state == S_IDLE || r_state == S_READ)) begin
                // pre_len_i is ADDR_W bits wide, so it never exceeds DEPTH-1.
                r_pre        <= pre_len_i;
                r_wptr       <= '0;
                r_cnt        <= '0;
                r_valid      <= 1'b0;
                r_last       <= 1'b0;
                r_skid_valid <= 1'b0;
                r_rd_pend    <= 1'b0;
                r_state      <= (pre_len_i == '0) ? S_WAIT_TRIG : S_PREFILL;
`ifdef CAPTURE_DECIM_EN
                r_decim      <= decim_i;
                r_dcnt       <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_PREFILL: begin
                        if (w_store) begin
                            r_wptr <= r_wptr + ADDR_W'(1);
                            if (r_cnt == r_pre - ADDR_W'(1)) begin
                                r_cnt   <= '0;
                                r_state <= S_WAIT_TRIG;
                            end else begin
                                r_cnt <= r_cnt + ADDR_W'(1);
                            end
                        end
                    end
                    S_WAIT_TRIG: begin
                        if (w_store) begin
                            r_wptr <= r_wptr + ADDR_W'(1);
                        end
                        if (w_trig) begin
                            r_trig_addr <= r_wptr;
                            r_cnt       <= '0;
                            if (w_post_len == '0) begin
                                r_raddr   <= r_wptr - r_pre;
                                r_issued  <= '0;
                                r_rd_done <= 1'b0;
                                r_state   <= S_READ;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (w_store) begin
                            r_wptr <= r_wptr + ADDR_W'(1);
                            if (r_cnt == w_post_len - ADDR_W'(1)) begin
                                r_raddr   <= r_trig_addr - r_pre;
                                r_issued  <= '0;
                                r_rd_done <= 1'b0;
                                r_state   <= S_READ;
                            end else begin
                                r_cnt <= r_cnt + ADDR_W'(1);
                            end
                        end
                    end
                    S_READ: begin
                        if (w_issue) begin
                            r_raddr   <= r_raddr + ADDR_W'(1);
                            r_issued  <= r_issued + ADDR_W'(1);
                            r_rd_last <= (r_issued == '1);
                            if (r_issued == '1) begin
                                r_rd_done <= 1'b1;
                            end
                        end
                        // RAM data lands in the output register when it is
                        // free, otherwise in the skid register.
                        if (w_xfer) begin
                            if (r_skid_valid) begin
                                r_out_data   <= r_skid_data;
                                r_last       <= r_skid_last;
                                r_skid_valid <= r_rd_pend;
                                r_skid_data  <= r_rdata;
                                r_skid_last  <= r_rd_last;
                            end else if (r_rd_pend) begin
                                r_out_data <= r_rdata;
                                r_last     <= r_rd_last;
                            end else begin
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                            end
                        end else if (r_rd_pend) begin
                            if (!r_valid) begin
                                r_out_data <= r_rdata;
                                r_last     <= r_rd_last;
                                r_valid    <= 1'b1;
                            end else begin
                                r_skid_data  <= r_rdata;
                                r_skid_last  <= r_rd_last;
                                r_skid_valid <= 1'b1;
                            end
                        end
                        if (w_xfer && r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign m_data_o    = r_out_data;
    assign m_valid_o   = r_valid;
    assign m_last_o    = r_last;
    assign state_o     = r_state;
    assign trig_addr_o = r_trig_addr;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_buffer
//
// Randomised bench for adc_capture_buffer with ADDR_W=4 (16-word records),
// two 14-bit channels. Each capture is modelled as a list of stored samples.
// The expected record is the pre_len samples before the trigger, the trigger
// sample, and the samples after it. The record is queued when the capture
// completes. A separate monitor pops one entry per handshake.
// ---------------------------------------------------------------------------
module tb_adc_capture_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [27:0] d;
        logic        last;
    } exp_t;

    logic        adc_clk_i = 1'b0;
    logic        adc_rst_i = 1'b0;
    logic [27:0] adc_dat_i = '0;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        ext_trig_i = 1'b0;
    logic [1:0]  trig_src_i = '0;
    logic [13:0] trig_lvl_i = '0;
    logic [3:0]  pre_len_i = '0;
    logic [15:0] decim_i = '0;
    logic [27:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic        m_last_o;
    logic [2:0]  state_o;
    logic [3:0]  trig_addr_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t expq[$];
    bit   readoutActive = 0;
    bit   stallPrev = 0;
    logic [27:0] stallData = '0;

    adc_capture_buffer #(.N_CH(2), .DATA_W(14), .ADDR_W(4)) dut (
        .adc_clk_i  (adc_clk_i),
        .adc_rst_i  (adc_rst_i),
        .adc_dat_i  (adc_dat_i),
        .arm_i      (arm_i),
        .abort_i    (abort_i),
        .ext_trig_i (ext_trig_i),
        .trig_src_i (trig_src_i),
        .trig_lvl_i (trig_lvl_i),
        .pre_len_i  (pre_len_i),
        .decim_i    (decim_i),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_last_o   (m_last_o),
        .state_o    (state_o),
        .trig_addr_o(trig_addr_o)
    );

    // Free-running ADC clock.
    always #5 adc_clk_i = ~adc_clk_i;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle of inputs, then step to just after the sampling edge.
    task automatic applyStimulus(input logic [27:0] d, input logic e, input logic arm,
                                 input logic ab, input logic rdy);
        adc_dat_i  = d;
        ext_trig_i = e;
        arm_i      = arm;
        abort_i    = ab;
        m_ready_i  = rdy;
        @(posedge adc_clk_i);
        #1;
        cyc++;
        arm_i   = 1'b0;
        abort_i = 1'b0;
    endtask

    function automatic logic [27:0] genData(input bit ramp);
        logic [31:0] r;
        logic [31:0] c;
        r = $urandom;
        c = cyc;
        if (ramp) return {r[13:0], c[13:0]};
        return r[27:0];
    endfunction

    // Trigger rule: signed upward crossing on a channel, or external rise.
    function automatic logic trigHit(input int src, input logic [13:0] lvl,
                                     input logic [27:0] pd, input logic [27:0] d,
                                     input logic pe, input logic e);
        if (src == 3) return e && !pe;
        if (src < 2) return ($signed(pd[src*14 +: 14]) < $signed(lvl)) &&
                            ($signed(d[src*14 +: 14]) >= $signed(lvl));
        return 1'b0;
    endfunction

    // Monitor: one expected word per handshake, and stalled words must hold.
    always @(negedge adc_clk_i) begin
        exp_t e;
        if (readoutActive && stallPrev) begin
            checks++;
            if (!(m_valid_o === 1'b1 && m_data_o === stallData)) begin
                errors++;
                $display("[TB] FAIL stall_hold: valid=%0b data=%h, expected valid=1 data=%h",
                         m_valid_o, m_data_o, stallData);
            end
        end
        stallPrev = readoutActive && m_valid_o && !m_ready_i;
        stallData = m_data_o;
        if (m_valid_o && m_ready_i) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_word: got %h, expected no word", m_data_o);
            end else begin
                e = expq.pop_front();
                if (m_data_o !== e.d || m_last_o !== e.last) begin
                    errors++;
                    $display("[TB] FAIL readout_word: got %h last=%0b, expected %h last=%0b",
                             m_data_o, m_last_o, e.d, e.last);
                end
            end
        end
    end

    // One capture from arm until the record is complete (phase 4). It can
    // also stop early. interrupt=1 aborts in POST and interrupt=2 resets in
    // POST. When the budget runs out the capture is aborted.
    task automatic runCapture(input int pre, input int src, input logic [13:0] lvl,
                              input bit ramp, input int extAt, input int budget,
                              input int interrupt);
        logic [27:0] hist[$];
        logic [27:0] prevD, d;
        logic        prevE, e, trig, store, rdy;
        int          phase, trigPos, lastStore, dec;
        logic [15:0] decimVal;
        exp_t        x;
        decimVal = 16'($urandom_range(0, 3));
`ifdef CAPTURE_DECIM_EN
        dec = int'(decimVal);
`else
        dec = 0;
`endif
        pre_len_i  = 4'(pre);
        trig_src_i = 2'(src);
        trig_lvl_i = lvl;
        decim_i    = decimVal;
        expq.delete();
        d = genData(ramp);
        applyStimulus(d, 1'b0, 1'b1, 1'b0, 1'b0);
        readoutActive = 0;
        phase = (pre == 0) ? 2 : 1;
        checkOutput("arm_state", int'(state_o), phase);
        checkOutput("arm_valid", int'(m_valid_o), 0);
        prevD = d;
        prevE = 1'b0;
        lastStore = 0;
        trigPos = 0;
        for (int rel = 1; rel <= budget + 1; rel++) begin
            if ((phase == 3 && interrupt == 1) || rel > budget) begin
                applyStimulus(genData(0), 1'b0, 1'b0, 1'b1, 1'b1);
                checkOutput("abort_state", int'(state_o), 0);
                checkOutput("abort_valid", int'(m_valid_o), 0);
                return;
            end
            if (phase == 3 && interrupt == 2) begin
                adc_rst_i = 1'b1;
                applyStimulus(genData(0), 1'b0, 1'b0, 1'b0, 1'b1);
                checkOutput("reset_state", int'(state_o), 0);
                checkOutput("reset_valid", int'(m_valid_o), 0);
                checkOutput("reset_trig_addr", int'(trig_addr_o), 0);
                applyStimulus(genData(0), 1'b0, 1'b0, 1'b0, 1'b1);
                applyStimulus(genData(0), 1'b0, 1'b0, 1'b0, 1'b1);
                adc_rst_i = 1'b0;
                applyStimulus(genData(0), 1'b0, 1'b0, 1'b0, 1'b1);
                checkOutput("post_reset_state", int'(state_o), 0);
                return;
            end
            d     = genData(ramp);
            e     = (extAt >= 0 && rel >= extAt);
            trig  = (phase == 2) && trigHit(src, lvl, prevD, d, prevE, e);
            store = trig || (rel - lastStore == dec + 1);
            if (store) begin
                hist.push_back(d);
                lastStore = rel;
            end
            if (phase == 1 && store && hist.size() == pre) begin
                phase = 2;
            end else if (phase == 2 && trig) begin
                trigPos = hist.size() - 1;
                phase = (pre == DEPTH - 1) ? 4 : 3;
            end else if (phase == 3 && store && (hist.size() - 1 - trigPos) == DEPTH - 1 - pre) begin
                phase = 4;
            end
            rdy = 1'($urandom_range(0, 1));
            applyStimulus(d, e, 1'b0, 1'b0, rdy);
            checkOutput("capture_state", int'(state_o), phase);
            if (phase == 4) begin
                for (int i = 0; i < DEPTH; i++) begin
                    x.d    = hist[trigPos - pre + i];
                    x.last = (i == DEPTH - 1);
                    expq.push_back(x);
                end
                readoutActive = 1;
                return;
            end
            prevD = d;
            prevE = e;
        end
    endtask

    // Drain the record with optional random backpressure. rearmAfter>0
    // leaves READ early so that the next capture can arm during readout.
    task automatic runReadout(input bit bp, input int rearmAfter);
        logic rdy;
        for (int k = 1; k <= 40 * DEPTH; k++) begin
            if (rearmAfter > 0 && k == rearmAfter) return;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(genData(0), 1'b0, 1'b0, 1'b0, rdy);
            if (k == 1) checkOutput("read_latency_1", int'(m_valid_o), 0);
            if (k == 2) checkOutput("read_latency_2", int'(m_valid_o), 1);
            if (expq.size() == 0) begin
                readoutActive = 0;
                checkOutput("end_state", int'(state_o), 0);
                checkOutput("end_valid", int'(m_valid_o), 0);
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL readout_timeout: got %0d words left, expected 0", expq.size());
        expq.delete();
        readoutActive = 0;
        applyStimulus(genData(0), 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Main scenario sequence.
    initial begin
        int pre, src, extAt;
        adc_rst_i = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", int'(state_o), 0);
        checkOutput("rst_valid", int'(m_valid_o), 0);
        checkOutput("rst_last", int'(m_last_o), 0);
        checkOutput("rst_data", int'(m_data_o), 0);
        checkOutput("rst_trig_addr", int'(trig_addr_o), 0);
        adc_rst_i = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] ramp, level trigger at 100 on ch0");
        runCapture(4, 0, 14'd100, 1, -1, 200, 0);
        runReadout(0, 0);

        $display("[TB] external trigger, no pre-trigger samples");
        runCapture(0, 3, 14'd0, 0, int'($urandom_range(1, 20)), 100, 0);
        runReadout(0, 0);

        $display("[TB] level trigger on ch1 with backpressure");
        runCapture(6, 1, 14'd0, 0, -1, 8 * DEPTH, 0);
        runReadout(1, 0);

        $display("[TB] long wait in WAIT_TRIG before external trigger");
        runCapture(5, 3, 14'd0, 0, 5 + 3 * DEPTH + 3, 200, 0);
        runReadout(1, 0);

        $display("[TB] unsupported trigger source, capture aborted");
        runCapture(3, 2, 14'd0, 0, -1, 4 * DEPTH, 0);

        $display("[TB] abort and reset while in POST");
        runCapture(8, 3, 14'd0, 0, 12, 100, 1);
        runCapture(2, 3, 14'd0, 0, 6, 100, 2);

        $display("[TB] re-arm during readout");
        runCapture(7, 0, 14'd0, 0, -1, 8 * DEPTH, 0);
        runReadout(1, 6);
        runCapture(15, 3, 14'd0, 0, 20, 100, 0);
        runReadout(1, 0);

        $display("[TB] random captures");
        for (int n = 0; n < 8; n++) begin
            pre = (n == 0) ? 0 : (n == 1) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
            src = (n % 3 == 2) ? 3 : n % 3;
            extAt = pre + int'($urandom_range(1, 20));
            runCapture(pre, src, 14'($urandom_range(0, 16383)), 0, extAt, extAt + 8 * DEPTH, 0);
            if (readoutActive) runReadout(1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
